// File: rtl/watch_mode_display_controller.sv
// Top-level sequencer for the multifunction watch: mode FSM, button routing,
// display value selection, digit scan and cook-timeout blinking.
module watch_mode_display_controller #(
    parameter int unsigned SCAN_DIV  = 17,
    parameter int unsigned BLINK_DIV = 26
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        mode_btn_pedge,
    input  logic [3:0]  btn_in,
    input  logic [15:0] watch_value,
    input  logic [15:0] stop_value,
    input  logic [15:0] cook_value,
    input  logic        cook_timeout,
    output logic [3:0]  watch_btn,
    output logic [3:0]  stop_btn,
    output logic [3:0]  cook_btn,
    output logic [1:0]  mode,
    output logic [2:0]  mode_led,
    output logic [3:0]  com,
    output logic [3:0]  hex_digit
);

    typedef enum logic [1:0] {
        StWatch = 2'b00,
        StStop  = 2'b01,
        StCook  = 2'b10
    } mode_e;

    mode_e                mode_q, mode_d;
    logic [2:0]           led_d;
    logic                 suppress_q;
    logic [SCAN_DIV-1:0]  scan_cnt_q;
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic [3:0]           com_ring_q;
    logic [15:0]          value_sel;

    // The timeout overrides the mode button unconditionally.
    always_comb begin
        mode_d = mode_q;
        if (cook_timeout) begin
            mode_d = StCook;
        end else if (mode_btn_pedge) begin
            unique case (mode_q)
                StWatch: mode_d = StStop;
                StStop:  mode_d = StCook;
                StCook:  mode_d = StWatch;
                default: mode_d = StWatch;
            endcase
        end
    end

    always_comb begin
        led_d = 3'b001;
        unique case (mode_d)
            StWatch: led_d = 3'b001;
            StStop:  led_d = 3'b010;
            StCook:  led_d = 3'b100;
            default: led_d = 3'b001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            mode_q      <= StWatch;
            mode_led    <= 3'b001;
            suppress_q  <= 1'b1;
            scan_cnt_q  <= '0;
            blink_cnt_q <= '0;
            com_ring_q  <= 4'b1110;
        end else begin
            mode_q     <= mode_d;
            mode_led   <= led_d;
            // A mode change blocks buttons until every button has been released.
            suppress_q <= (mode_d != mode_q) | (suppress_q & (btn_in != 4'b0000));
            scan_cnt_q <= scan_cnt_q + 1'b1;
            if (&scan_cnt_q) begin
                com_ring_q <= {com_ring_q[2:0], com_ring_q[3]};
            end
            blink_cnt_q <= cook_timeout ? blink_cnt_q + 1'b1 : '0;
        end
    end

    assign mode = mode_q;

    always_comb begin
        watch_btn = 4'b0000;
        stop_btn  = 4'b0000;
        cook_btn  = 4'b0000;
        if (!suppress_q) begin
            unique case (mode_q)
                StWatch: watch_btn = btn_in;
                StStop:  stop_btn  = btn_in;
                StCook:  cook_btn  = btn_in;
                default: ;
            endcase
        end
    end

    always_comb begin
        value_sel = watch_value;
        unique case (mode_q)
            StWatch: value_sel = watch_value;
            StStop:  value_sel = stop_value;
            StCook:  value_sel = cook_value;
            default: value_sel = watch_value;
        endcase
    end

    always_comb begin
        hex_digit = 4'h0;
        unique case (com_ring_q)
            4'b1110: hex_digit = value_sel[3:0];
            4'b1101: hex_digit = value_sel[7:4];
            4'b1011: hex_digit = value_sel[11:8];
            4'b0111: hex_digit = value_sel[15:12];
            default: hex_digit = 4'h0;
        endcase
    end

    // Blanking only masks the output; the scan ring keeps rotating underneath.
    assign com = (cook_timeout && blink_cnt_q[BLINK_DIV-1]) ? 4'b1111 : com_ring_q;

endmodule

// File: tb/tb_watch_mode_display_controller.sv
// Scoreboard bench for watch_mode_display_controller with small scan/blink dividers.
module tb_watch_mode_display_controller;

    localparam int unsigned ScanDiv  = 2;
    localparam int unsigned BlinkDiv = 3;

    logic        clk;
    logic        reset_p;
    logic        mode_btn_pedge;
    logic [3:0]  btn_in;
    logic [15:0] watch_value;
    logic [15:0] stop_value;
    logic [15:0] cook_value;
    logic        cook_timeout;
    logic [3:0]  watch_btn;
    logic [3:0]  stop_btn;
    logic [3:0]  cook_btn;
    logic [1:0]  mode;
    logic [2:0]  mode_led;
    logic [3:0]  com;
    logic [3:0]  hex_digit;

    watch_mode_display_controller #(
        .SCAN_DIV  (ScanDiv),
        .BLINK_DIV (BlinkDiv)
    ) dut (
        .clk            (clk),
        .reset_p        (reset_p),
        .mode_btn_pedge (mode_btn_pedge),
        .btn_in         (btn_in),
        .watch_value    (watch_value),
        .stop_value     (stop_value),
        .cook_value     (cook_value),
        .cook_timeout   (cook_timeout),
        .watch_btn      (watch_btn),
        .stop_btn       (stop_btn),
        .cook_btn       (cook_btn),
        .mode           (mode),
        .mode_led       (mode_led),
        .com            (com),
        .hex_digit      (hex_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] led;
        logic [3:0] com;
        logic [3:0] hex;
        logic [3:0] wb;
        logic [3:0] sb;
        logic [3:0] cb;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: digit index instead of a ring, plain integer counters.
    int m_mode  = 0;
    int m_sup   = 1;
    int m_scan  = 0;
    int m_digit = 0;
    int m_blink = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic pedge, input logic [3:0] btn,
                        input logic tmo);
        exp_t        e;
        int          nxt;
        logic [15:0] val;
        logic [3:0]  ring;
        @(negedge clk);
        reset_p        = rst;
        mode_btn_pedge = pedge;
        btn_in         = btn;
        cook_timeout   = tmo;
        if (rst) begin
            m_mode = 0; m_sup = 1; m_scan = 0; m_digit = 0; m_blink = 0;
        end else begin
            if (tmo)        nxt = 2;
            else if (pedge) nxt = (m_mode + 1) % 3;
            else            nxt = m_mode;
            if (nxt != m_mode) m_sup = 1;
            else if (btn == 4'b0000) m_sup = 0;
            m_mode = nxt;
            if (m_scan == (1 << ScanDiv) - 1) m_digit = (m_digit + 1) % 4;
            m_scan  = (m_scan + 1) % (1 << ScanDiv);
            m_blink = tmo ? (m_blink + 1) % (1 << BlinkDiv) : 0;
        end
        val = (m_mode == 0) ? watch_value : (m_mode == 1) ? stop_value : cook_value;
        ring = 4'hF ^ (4'b0001 << m_digit);
        e.mode = 2'(m_mode);
        e.led  = 3'b001 << m_mode;
        e.com  = (tmo && m_blink >= (1 << (BlinkDiv - 1))) ? 4'hF : ring;
        e.hex  = val[m_digit*4 +: 4];
        e.wb   = (!m_sup && m_mode == 0) ? btn : 4'h0;
        e.sb   = (!m_sup && m_mode == 1) ? btn : 4'h0;
        e.cb   = (!m_sup && m_mode == 2) ? btn : 4'h0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("mode",      16'(mode),      16'(e.mode));
        check_eq("mode_led",  16'(mode_led),  16'(e.led));
        check_eq("com",       16'(com),       16'(e.com));
        check_eq("hex_digit", 16'(hex_digit), 16'(e.hex));
        check_eq("watch_btn", 16'(watch_btn), 16'(e.wb));
        check_eq("stop_btn",  16'(stop_btn),  16'(e.sb));
        check_eq("cook_btn",  16'(cook_btn),  16'(e.cb));
    endtask

    task automatic idle(input int n, input logic [3:0] btn, input logic tmo);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, btn, tmo);
    endtask

    initial begin
        reset_p        = 1'b1;
        mode_btn_pedge = 1'b0;
        btn_in         = 4'h0;
        cook_timeout   = 1'b0;
        watch_value    = 16'h5678;
        stop_value     = 16'h1234;
        cook_value     = 16'h9abc;

        // Reset state.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("rst_mode", 16'(mode), 16'h0);
        check_eq("rst_com",  16'(com),  16'he);

        // Mode cycling, pulses 10 cycles apart.
        for (int p = 0; p < 3; p++) begin
            step(1'b0, 1'b1, 4'h0, 1'b0);
            idle(9, 4'h0, 1'b0);
        end
        check_eq("cycle_back_watch", 16'(mode_led), 16'h1);

        // Button held across WATCH->STOP is blocked until released.
        step(1'b0, 1'b1, 4'h0, 1'b0);
        idle(5, 4'b0010, 1'b0);
        check_eq("held_blocked", 16'(stop_btn), 16'h0);
        idle(3, 4'h0, 1'b0);
        idle(3, 4'b0010, 1'b0);
        check_eq("second_press", 16'(stop_btn), 16'h2);
        idle(2, 4'h0, 1'b0);

        // Digit scan in STOP mode over two full rotations.
        idle(32, 4'h0, 1'b0);

        // Back to WATCH, then timeout raised with a mode pulse.
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0);
        idle(3, 4'h0, 1'b0);
        check_eq("pre_tmo_watch", 16'(mode), 16'h0);
        step(1'b0, 1'b1, 4'h0, 1'b1);
        check_eq("tmo_forces_cook", 16'(mode), 16'h2);
        for (int c = 1; c < 18; c++) step(1'b0, (c % 3) == 0, 4'h0, 1'b1);
        idle(6, 4'h0, 1'b0);
        check_eq("tmo_drop_stays_cook", 16'(mode), 16'h2);

        // Reset mid-scan and mid-timeout with a button held through it.
        idle(5, 4'b0001, 1'b1);
        step(1'b1, 1'b0, 4'b0001, 1'b1);
        check_eq("mid_rst_mode", 16'(mode), 16'h0);
        check_eq("mid_rst_com",  16'(com),  16'he);
        idle(4, 4'b0001, 1'b0);
        check_eq("post_rst_blocked", 16'(watch_btn), 16'h0);
        idle(2, 4'h0, 1'b0);
        idle(3, 4'b0100, 1'b0);
        check_eq("post_rst_release", 16'(watch_btn), 16'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/watch_mode_display_controller.md
Name: watch_mode_display_controller

Overview:
- Top-level sequencer for the multifunction watch.
- Owns the mode state machine (clock / stopwatch / cook timer) and routes the shared push-buttons to the active function only.
- Selects that function's 16-bit BCD value and time-multiplexes it onto the 4-digit common-anode 7-segment display.
- Handles the cook-timer timeout: forces cook mode and blinks the display while the timeout is active.

Parameters:
- SCAN_DIV, 17: width of the digit-scan divider; the active digit advances every 2^SCAN_DIV clocks.
- BLINK_DIV, 26: width of the blink divider; the display blanks while the divider MSB is 1 during a timeout.

Ports:
- clk  in  1  system clock; the only clock.
- reset_p  in  1  reset, synchronous and active-high.
- mode_btn_pedge  in  1  debounced single-cycle pulse that cycles the mode.
- btn_in  in  4  debounced function-button levels/pulses, shared by all functions.
- watch_value  in  16  BCD {min10,min1,sec10,sec1} from the clock function.
- stop_value  in  16  BCD from the stopwatch.
- cook_value  in  16  BCD from the cook timer.
- cook_timeout  in  1  level; high while the cook-timer alarm is active.
- watch_btn  out  4  btn_in gated to the clock function.
- stop_btn  out  4  btn_in gated to the stopwatch.
- cook_btn  out  4  btn_in gated to the cook timer.
- mode  out  2  00 clock, 01 stopwatch, 10 cook; 11 is never produced.
- mode_led  out  3  one-hot mode indicator {cook,stop,watch}.
- com  out  4  active-low digit enable; bit0 = rightmost digit.
- hex_digit  out  4  BCD nibble for the currently enabled digit; feeds the 7-seg decoder.

Behaviour:
- All state updates on posedge clk. reset_p has priority over every other input.
- Reset values:
  - mode=00, mode_led=001, com=4'b1110.
  - scan_cnt=0, blink_cnt=0.
  - suppress=1; all *_btn outputs=0.
- Mode FSM:
  - WATCH -> STOP -> COOK -> WATCH on each mode_btn_pedge. Change is visible the cycle after the pulse.
  - mode_led is a registered decode of mode, updated in the same cycle as mode.
- Timeout override:
  - While cook_timeout=1: mode is forced to COOK next cycle and mode_btn_pedge is ignored.
  - cook_timeout=1 in the same cycle as mode_btn_pedge: the timeout wins and mode becomes COOK.
  - On cook_timeout falling, mode stays COOK.
- Button routing (combinational from registered mode/suppress):
  - Active function's *_btn = btn_in; the other two = 0.
  - When suppress=1, all three = 0.
- Suppress:
  - Set on reset, on any mode change (button-driven or forced), and held while btn_in != 0.
  - Cleared on the first cycle btn_in == 4'b0000 with no mode change that cycle.
  - Result: a button held across a mode switch never reaches the new function.
- Display value: value_sel = watch_value / stop_value / cook_value per mode. No extra latency; follows mode.
- Digit scan:
  - scan_cnt (SCAN_DIV bits) increments every cycle and wraps.
  - When scan_cnt is all ones, com rotates next cycle: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - First rotation occurs 2^SCAN_DIV cycles after reset release.
- hex_digit:
  - value_sel[3:0] for com=1110, [7:4] for 1101, [11:8] for 1011, [15:12] for 0111.
  - Combinational from registered com.
- Blink:
  - blink_cnt (BLINK_DIV bits) increments each cycle while cook_timeout=1; held at 0 while cook_timeout=0.
  - While cook_timeout=1 and blink_cnt MSB=1, the com output is forced to 4'b1111. The internal ring keeps rotating.
- Width rules: counters wrap modulo 2^N; no saturation; no BCD checking of inputs (pass-through).

Test Plan:
1. Reset, then 3 mode_btn_pedge pulses 10 cycles apart:
   - mode 00 -> 01 -> 10 -> 00.
   - mode_led 001 -> 010 -> 100 -> 001, each change one cycle after its pulse.
2. btn_in=4'b0010 held across a mode switch WATCH->STOP, released, then pulsed again:
   - stop_btn=0 while held.
   - stop_btn=0010 on the second press; watch_btn=0 throughout.
3. SCAN_DIV=2, stop mode, stop_value=16'h1234:
   - com 1110/1101/1011/0111 each for 4 cycles.
   - hex_digit 4/3/2/1 correspondingly; pattern repeats.
4. Timeout in WATCH, BLINK_DIV=3:
   - Raise cook_timeout together with mode_btn_pedge -> mode=10 next cycle.
   - Further mode pulses ignored.
   - com=1111 on cycles 4-7, 12-15 of the timeout.
   - Drop cook_timeout -> blinking stops, mode stays 10.
5. Assert reset_p mid-scan and mid-timeout:
   - Next cycle: mode=00, com=1110, all *_btn=0.
   - Buttons stay blocked until btn_in reads 0.
